// File: rtl/capture_gray_subsystem.sv
// Capture/grayscale front end: sequencer FSM, RGB frame buffer (RWM_1)
// and a 3-byte-to-1 grayscaler feeding the external RWM_2.
module capture_gray_subsystem #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128
) (
  input  logic       clk,
  input  logic       rst_n,        // synchronous, active-HIGH
  input  logic       start,
  input  logic       clear,
  input  logic       cam_valid,
  input  logic [7:0] cam_data,
  output logic       cam_enable,
  input  logic       rwm2_done,
  output logic       rwm2_enable,
  output logic       rwm2_rw,
  output logic [7:0] gs_data,
  output logic       gs_valid,
  output logic       busy,
  output logic       frame_done
);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NBYTES = 3 * NPIX;
  localparam int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_BYTE = AW'(NBYTES - 1);
  localparam logic [PW-1:0] LAST_PIX  = PW'(NPIX - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_GRAY    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          rwm1_en_r;
  logic          rw1_r;
  logic          gs_en_r;
  logic [7:0]    mem_r [0:NBYTES-1];
  logic [AW-1:0] ptr_r;
  logic [7:0]    rd_data_r;
  logic          rd_valid_r;
  logic          rd_stop_r;
  logic [1:0]    bcnt_r;
  logic [PW-1:0] pcnt_r;
  logic [7:0]    red_r;
  logic [7:0]    grn_r;
  logic          wr_s;
  logic          rd_s;
  logic          pause_s;
  logic          rwm1_done_s;
  logic          gs_done_s;
  logic [9:0]    sum_s;
  logic [7:0]    gray_s;

  // Datapath strobes, done pulses and the weighted luminance sum.
  always_comb begin
    pause_s     = gs_valid;
    wr_s        = rwm1_en_r & rw1_r & cam_valid & ~clear;
    rd_s        = rwm1_en_r & ~rw1_r & ~pause_s & ~rd_stop_r & ~clear;
    rwm1_done_s = (wr_s | rd_s) & (ptr_r == LAST_BYTE);
    gs_done_s   = gs_valid & (pcnt_r == LAST_PIX);
    sum_s       = {2'b00, red_r} + {1'b0, grn_r, 1'b0} + {2'b00, rd_data_r};
    gray_s      = 8'(sum_s >> 2);
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_CAPTURE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_CAPTURE: begin
        if (rwm1_done_s) state_nxt_s = ST_GRAY;
        else             state_nxt_s = ST_CAPTURE;
      end
      ST_GRAY: begin
        if (gs_done_s) state_nxt_s = ST_DRAIN;
        else           state_nxt_s = ST_GRAY;
      end
      ST_DRAIN: begin
        if (rwm2_done) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and outputs registered from the next state so they
  // line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      cam_enable  <= 1'b0;
      rwm1_en_r   <= 1'b0;
      rw1_r       <= 1'b0;
      gs_en_r     <= 1'b0;
      rwm2_enable <= 1'b0;
      rwm2_rw     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cam_enable  <= (state_nxt_s == ST_CAPTURE);
      rwm1_en_r   <= (state_nxt_s == ST_CAPTURE) | (state_nxt_s == ST_GRAY);
      rw1_r       <= (state_nxt_s == ST_CAPTURE);
      gs_en_r     <= (state_nxt_s == ST_GRAY);
      rwm2_enable <= (state_nxt_s == ST_GRAY) | (state_nxt_s == ST_DRAIN);
      rwm2_rw     <= (state_nxt_s == ST_GRAY);
      busy        <= (state_nxt_s != ST_IDLE);
      frame_done  <= (state_r == ST_DRAIN) & rwm2_done;
    end
  end

  // Frame buffer storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[ptr_r] <= cam_data;
  end

  // Shared read/write pointer, read register and end-of-frame read stop.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr_r      <= {AW{1'b0}};
      rd_data_r  <= 8'd0;
      rd_valid_r <= 1'b0;
      rd_stop_r  <= 1'b0;
    end else if (clear) begin
      ptr_r      <= {AW{1'b0}};
      rd_valid_r <= 1'b0;
      rd_stop_r  <= 1'b0;
    end else begin
      if (wr_s) begin
        ptr_r      <= rwm1_done_s ? {AW{1'b0}} : ptr_r + AW'(1);
        rd_valid_r <= 1'b0;
      end else if (rd_s) begin
        rd_data_r  <= mem_r[ptr_r];
        rd_valid_r <= 1'b1;
        ptr_r      <= rwm1_done_s ? {AW{1'b0}} : ptr_r + AW'(1);
      end else begin
        rd_valid_r <= 1'b0;
      end
      // Once the last byte is read, hold off until the buffer is re-enabled.
      rd_stop_r <= rwm1_en_r & (rd_stop_r | (rd_s & rwm1_done_s));
    end
  end

  // Grayscaler: gather R,G,B then emit one averaged pixel, stalling reads a cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bcnt_r   <= 2'd0;
      pcnt_r   <= {PW{1'b0}};
      red_r    <= 8'd0;
      grn_r    <= 8'd0;
      gs_data  <= 8'd0;
      gs_valid <= 1'b0;
    end else if (!gs_en_r) begin
      bcnt_r   <= 2'd0;
      pcnt_r   <= {PW{1'b0}};
      gs_valid <= 1'b0;
    end else begin
      gs_valid <= rd_valid_r & (bcnt_r == 2'd2);
      if (rd_valid_r) begin
        case (bcnt_r)
          2'd0: begin
            red_r  <= rd_data_r;
            bcnt_r <= 2'd1;
          end
          2'd1: begin
            grn_r  <= rd_data_r;
            bcnt_r <= 2'd2;
          end
          default: begin
            gs_data <= gray_s;
            bcnt_r  <= 2'd0;
          end
        endcase
      end
      if (gs_valid) pcnt_r <= gs_done_s ? {PW{1'b0}} : pcnt_r + PW'(1);
    end
  end

endmodule

// File: tb/tb_capture_gray_subsystem.sv
// Directed bench for capture_gray_subsystem on a 2x1 image (6 bytes).
module tb_capture_gray_subsystem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       cam_valid = 1'b0;
  logic [7:0] cam_data = 8'd0;
  logic       rwm2_done = 1'b0;
  logic       cam_enable, rwm2_enable, rwm2_rw, gs_valid, busy, frame_done;
  logic [7:0] gs_data;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  logic [7:0] gs_q [$];

  typedef struct {
    logic [5:0][7:0] bytes;   // bytes[0] is sent first
    logic [7:0]      e0;
    logic [7:0]      e1;
    int              gap_at;  // byte index preceded by a cam_valid gap, -1 none
    int              mode;    // 0 plain, 1 clear preamble, 2 start in GRAY, 3 idle junk
  } vec_t;

  vec_t vecs [6];

  capture_gray_subsystem #(.IMG_W(2), .IMG_H(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .cam_valid(cam_valid), .cam_data(cam_data), .cam_enable(cam_enable),
    .rwm2_done(rwm2_done), .rwm2_enable(rwm2_enable), .rwm2_rw(rwm2_rw),
    .gs_data(gs_data), .gs_valid(gs_valid), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Output monitor on the inactive edge.
  always @(negedge clk) begin
    if (gs_valid) gs_q.push_back(gs_data);
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cam_enable(input string name);
    int k;
    k = 0;
    while (!cam_enable && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_cam_enable"}, 32'(cam_enable), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr);
    cam_valid = 1'b1;
    cam_data  = b;
    clear     = clr;
    @(negedge clk);
    cam_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int k;
    int fd_base;
    gs_q.delete();
    fd_base = fd_cnt;
    if (v.mode == 3) begin
      // camera bytes while idle must not land in the buffer
      cam_valid = 1'b1;
      cam_data  = 8'd99;
      repeat (3) @(negedge clk);
      cam_valid = 1'b0;
      chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cam_enable(name);
    if (v.mode == 1) begin
      send_byte(8'd77, 1'b0);
      send_byte(8'd88, 1'b1);   // clear wins over this write
    end
    for (int i = 0; i < 6; i++) begin
      if (i == v.gap_at) begin
        repeat (3) @(negedge clk);
        chk({name, "_gap_hold"}, 32'(cam_enable), 32'd1);
      end
      send_byte(v.bytes[i], 1'b0);
    end
    chk({name, "_gray_entry"}, 32'({rwm2_enable, rwm2_rw, cam_enable}), 32'b110);
    if (v.mode == 2) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, "_start_ignored"}, 32'({rwm2_enable, rwm2_rw, cam_enable, busy}), 32'b1101);
    end
    k = 0;
    while (!(rwm2_enable && !rwm2_rw) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_reach_drain"}, 32'(rwm2_enable && !rwm2_rw), 32'd1);
    chk({name, "_gs_count"}, 32'(gs_q.size()), 32'd2);
    if (gs_q.size() == 2) begin
      chk({name, "_gs0"}, 32'(gs_q[0]), 32'(v.e0));
      chk({name, "_gs1"}, 32'(gs_q[1]), 32'(v.e1));
    end
    chk({name, "_drain_busy"}, 32'(busy), 32'd1);
    rwm2_done = 1'b1;
    @(negedge clk);
    rwm2_done = 1'b0;
    chk({name, "_frame_done"}, 32'({frame_done, busy, rwm2_enable}), 32'b100);
    @(negedge clk);
    chk({name, "_fd_once"}, 32'(fd_cnt - fd_base), 32'd1);
    chk({name, "_idle_after"}, 32'({frame_done, busy}), 32'b00);
  endtask

  initial begin
    vecs[0] = '{bytes: {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10},   e0: 8'd20,  e1: 8'd50,  gap_at: -1, mode: 0};
    vecs[1] = '{bytes: {8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255},   e0: 8'd255, e1: 8'd0,   gap_at: -1, mode: 0};
    vecs[2] = '{bytes: {8'd3, 8'd3, 8'd3, 8'd3, 8'd2, 8'd1},         e0: 8'd2,   e1: 8'd3,   gap_at: 2,  mode: 0};
    vecs[3] = '{bytes: {8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0},   e0: 8'd127, e1: 8'd127, gap_at: -1, mode: 2};
    vecs[4] = '{bytes: {8'd0, 8'd1, 8'd1, 8'd50, 8'd200, 8'd100},    e0: 8'd137, e1: 8'd0,   gap_at: -1, mode: 1};
    vecs[5] = '{bytes: {8'd6, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7},         e0: 8'd1,   e1: 8'd1,   gap_at: 4,  mode: 3};

    // reset held two cycles
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        32'({cam_enable, rwm2_enable, rwm2_rw, gs_valid, busy, frame_done}), 32'd0);
    chk("reset_gs_data", 32'(gs_data), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // abort mid-capture, then a full frame must land from address 0
    begin
      int fd_base;
      fd_base = fd_cnt;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cam_enable("abort");
      send_byte(8'd11, 1'b0);
      send_byte(8'd22, 1'b0);
      send_byte(8'd33, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_reset", 32'({busy, cam_enable, frame_done}), 32'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_no_frame_done", 32'(fd_cnt - fd_base), 32'd0);
      run_frame(vecs[0], "recapture");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
